// File: rtl/dm_pipe.sv
// Parametrised single-port data memory with byte-lane writes, a configurable
// read-latency pipeline, a read-valid strobe and sticky collision/range flags.
module dm_pipe #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 13,
  parameter int RD_LAT      = 1,
  parameter int CHECK_RANGE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                re,
  input  logic [DATA_W/8-1:0] we,
  input  logic [DATA_W-1:0]   wrt_data,
  input  logic                clr_err,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_vld,
  output logic                col_err,
  output logic                addr_err
);

  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  wr_req;
  logic                  collide;
  logic                  out_of_range;
  logic                  do_wr;
  logic                  do_rd;
  logic [DATA_W-1:0]     rd_sample;
  logic                  tail_vld;
  logic [DATA_W-1:0]     tail_data;

  assign idx = addr[DEPTH_LOG2-1:0];

  always_comb begin
    wr_req       = |we;
    collide      = re & wr_req;
    out_of_range = (CHECK_RANGE != 0) && (addr[ADDR_W-1:DEPTH_LOG2] != '0);
    do_wr        = wr_req & ~re & ~out_of_range & ~rst;
    do_rd        = re & ~wr_req;
    rd_sample    = out_of_range ? '0 : mem[idx];
  end

  // Array has no reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (we[i]) mem[idx][8*i +: 8] <= wrt_data[8*i +: 8];
      end
    end
  end

  generate
    if (RD_LAT == 1) begin : g_direct
      assign tail_vld  = do_rd;
      assign tail_data = rd_sample;
    end else begin : g_delay
      logic [RD_LAT-2:0] vld_q;
      logic [DATA_W-1:0] data_q [RD_LAT-1];

      // The array sample is captured at the request edge; the output
      // register below supplies the last of the RD_LAT stages.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= do_rd;
          for (int unsigned i = 1; i < RD_LAT - 1; i++) vld_q[i] <= vld_q[i-1];
        end
        data_q[0] <= rd_sample;
        for (int unsigned i = 1; i < RD_LAT - 1; i++) data_q[i] <= data_q[i-1];
      end

      assign tail_vld  = vld_q[RD_LAT-2];
      assign tail_data = data_q[RD_LAT-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld   <= 1'b0;
      rd_data  <= '0;
      col_err  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_vld <= tail_vld;
      if (tail_vld) rd_data <= tail_data;
      col_err  <= collide | (col_err & ~clr_err);
      addr_err <= (out_of_range & (re | wr_req) & ~collide) | (addr_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_dm_pipe.sv
// Scoreboard bench for dm_pipe: two instances (RD_LAT=3 range-checked,
// RD_LAT=1 truncating) share stimulus and are compared against array models.
module tb_dm_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic        re = 1'b0;
  logic [1:0]  we = '0;
  logic [15:0] wrt_data = '0;
  logic        clr_err = 1'b0;

  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_vld_a, rd_vld_b, col_err_a, col_err_b, addr_err_a, addr_err_b;

  dm_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(13), .RD_LAT(3), .CHECK_RANGE(1)) u_a (
    .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .wrt_data(wrt_data),
    .clr_err(clr_err), .rd_data(rd_data_a), .rd_vld(rd_vld_a),
    .col_err(col_err_a), .addr_err(addr_err_a));

  dm_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(13), .RD_LAT(1), .CHECK_RANGE(0)) u_b (
    .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .wrt_data(wrt_data),
    .clr_err(clr_err), .rd_data(rd_data_b), .rd_vld(rd_vld_b),
    .col_err(col_err_b), .addr_err(addr_err_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  exp_t        qa[$], qb[$];
  logic [15:0] ma [int];
  logic [15:0] mb [int];
  logic        ca = 0, aa = 0, cb = 0;
  logic [15:0] lasta = '0, lastb = '0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_on = 0;

  always @(posedge clk) cyc++;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] w);
    logic [15:0] r;
    r = old;
    if (w[0]) r[7:0]  = d[7:0];
    if (w[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // Drives one cycle of inputs and advances the models to the state after
  // the next rising edge.
  task automatic op(input logic [15:0] a, input logic r, input logic [1:0] w,
                    input logic [15:0] d, input logic c, input logic rs);
    logic col, oor;
    int   ix;
    @(negedge clk); #1;
    addr = a; re = r; we = w; wrt_data = d; clr_err = c; rst = rs;
    ix  = int'(a[12:0]);
    col = r && (w != 0);
    oor = (a[15:13] != 0);
    if (rs) begin
      qa.delete(); qb.delete();
      ca = 0; aa = 0; cb = 0; lasta = '0; lastb = '0;
    end else begin
      ca = col || (ca && !c);
      aa = (oor && (r || w != 0) && !col) || (aa && !c);
      cb = col || (cb && !c);
      if (w != 0 && !r && !oor) ma[ix] = merge(ma.exists(ix) ? ma[ix] : 16'h0, d, w);
      if (w != 0 && !r)         mb[ix] = merge(mb.exists(ix) ? mb[ix] : 16'h0, d, w);
      if (r && w == 0) begin
        qa.push_back('{d: (oor ? 16'h0 : ma[ix]), due: cyc + 3});
        qb.push_back('{d: mb[ix], due: cyc + 1});
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      exp_t e;
      checks++;
      if (rd_vld_a) begin
        if (qa.size() == 0) begin
          failures++; $display("FAIL a_spurious_vld got rd_data=%h cyc=%0d", rd_data_a, cyc);
        end else begin
          e = qa.pop_front();
          lasta = e.d;
          if (e.due != cyc || rd_data_a !== e.d) begin
            failures++;
            $display("FAIL a_read got data=%h cyc=%0d want data=%h cyc=%0d", rd_data_a, cyc, e.d, e.due);
          end
        end
      end else if (qa.size() > 0 && qa[0].due <= cyc) begin
        e = qa.pop_front();
        lasta = e.d;
        failures++; $display("FAIL a_missing_vld got rd_vld=0 want rd_vld=1 data=%h cyc=%0d", e.d, cyc);
      end else if (rd_data_a !== lasta) begin
        failures++; $display("FAIL a_hold got rd_data=%h want %h", rd_data_a, lasta);
      end

      checks++;
      if (rd_vld_b) begin
        if (qb.size() == 0) begin
          failures++; $display("FAIL b_spurious_vld got rd_data=%h cyc=%0d", rd_data_b, cyc);
        end else begin
          e = qb.pop_front();
          lastb = e.d;
          if (e.due != cyc || rd_data_b !== e.d) begin
            failures++;
            $display("FAIL b_read got data=%h cyc=%0d want data=%h cyc=%0d", rd_data_b, cyc, e.d, e.due);
          end
        end
      end else if (qb.size() > 0 && qb[0].due <= cyc) begin
        e = qb.pop_front();
        lastb = e.d;
        failures++; $display("FAIL b_missing_vld got rd_vld=0 want rd_vld=1 data=%h cyc=%0d", e.d, cyc);
      end else if (rd_data_b !== lastb) begin
        failures++; $display("FAIL b_hold got rd_data=%h want %h", rd_data_b, lastb);
      end

      checks++;
      if (col_err_a !== ca || addr_err_a !== aa) begin
        failures++;
        $display("FAIL a_flags got col=%b addr=%b want col=%b addr=%b", col_err_a, addr_err_a, ca, aa);
      end
      checks++;
      if (col_err_b !== cb || addr_err_b !== 1'b0) begin
        failures++;
        $display("FAIL b_flags got col=%b addr=%b want col=%b addr=0", col_err_b, addr_err_b, cb);
      end
    end
  end

  initial begin
    logic [15:0] a;
    logic [3:0]  lo;
    int          k;
    op(16'h0, 0, 2'b00, 16'h0, 0, 1);
    mon_on = 1;
    op(16'h0, 0, 2'b00, 16'h0, 0, 1);
    for (int i = 0; i < 16; i++) op(16'(i), 0, 2'b11, 16'($urandom), 0, 0);

    op(16'h0005, 0, 2'b11, 16'hBEEF, 0, 0);
    op(16'h0005, 1, 2'b00, 16'h0, 0, 0);
    op(16'h0007, 0, 2'b11, 16'h1234, 0, 0);
    op(16'h0007, 0, 2'b10, 16'hAB00, 0, 0);
    op(16'h0007, 1, 2'b00, 16'h0, 0, 0);
    op(16'h0001, 0, 2'b11, 16'h0011, 0, 0);
    op(16'h0002, 0, 2'b11, 16'h0022, 0, 0);
    op(16'h0003, 0, 2'b11, 16'h0033, 0, 0);
    op(16'h0001, 1, 2'b00, 16'h0, 0, 0);
    op(16'h0002, 1, 2'b00, 16'h0, 0, 0);
    op(16'h0003, 1, 2'b00, 16'h0, 0, 0);
    op(16'h0001, 1, 2'b00, 16'h0, 0, 0);
    op(16'h0001, 0, 2'b11, 16'h0099, 0, 0);
    op(16'h0001, 1, 2'b00, 16'h0, 0, 0);
    op(16'h0004, 0, 2'b11, 16'h5555, 0, 0);
    op(16'h0004, 1, 2'b11, 16'hFFFF, 0, 0);
    op(16'h0004, 1, 2'b00, 16'h0, 0, 0);
    op(16'h0000, 0, 2'b00, 16'h0, 1, 0);
    op(16'h2005, 0, 2'b11, 16'hCAFE, 0, 0);
    op(16'h2005, 1, 2'b00, 16'h0, 0, 0);
    op(16'h0005, 1, 2'b00, 16'h0, 0, 0);
    op(16'h2005, 1, 2'b11, 16'h0, 1, 0);
    op(16'h0003, 1, 2'b00, 16'h0, 0, 0);
    op(16'h0004, 1, 2'b00, 16'h0, 0, 0);
    op(16'h0000, 0, 2'b00, 16'h0, 0, 1);
    op(16'h0000, 0, 2'b00, 16'h0, 0, 0);
    op(16'h0000, 0, 2'b00, 16'h0, 0, 0);
    op(16'h0005, 1, 2'b00, 16'h0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      lo = 4'($urandom_range(0, 15));
      k  = int'($urandom_range(0, 5));
      a  = (k == 0) ? {12'h200, lo} : (k == 1) ? {12'h400, lo} : {12'h000, lo};
      k  = int'($urandom_range(0, 9));
      op(a, (k < 4) || (k == 8), (k >= 4 && k <= 8) ? 2'($urandom_range(1, 3)) : 2'b00,
         16'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0));
    end

    for (int i = 0; i < 6; i++) op(16'h0, 0, 2'b00, 16'h0, 0, 0);
    @(negedge clk); #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL drain got pending a=%0d b=%0d want 0", qa.size(), qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
